mem_access: RTL and testbench



---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage and the data memory.
// Request/grant/response handshake with byte enables.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32IM memory-access stage: bus transactions for loads/stores,
// lane formatting, registered writeback and pipeline stall.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    mem_access_if.master dbus,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] LB      = 4'd1;
    localparam logic [3:0] LH      = 4'd2;
    localparam logic [3:0] LW      = 4'd3;
    localparam logic [3:0] LBU     = 4'd4;
    localparam logic [3:0] LHU     = 4'd5;
    localparam logic [3:0] SB      = 4'd6;
    localparam logic [3:0] SH      = 4'd7;
    localparam logic [3:0] SW      = 4'd8;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           op_q;
    logic [31:0]          addr_q;
    logic [31:0]          data_q;
    logic                 we_q;
    logic [4:0]           mwaddr_q;
    logic [4:0]           reg_waddr_q;
    logic                 reg_we_q;
    logic [31:0]          reg_wdata_q;
    logic                 misalign_q;
    logic                 bus_err_q;

    logic is_mem, misal, stall, latch, done, tmo;
    logic [31:0] ld_data;

    always_comb begin
        is_mem = (mem_op_i != MEM_NOP) && (mem_op_i <= SW);
        misal  = 1'b0;
        case (mem_op_i)
            LH, LHU, SH: misal = mem_addr_i[0];
            LW, SW:      misal = |mem_addr_i[1:0];
            default:     misal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        latch   = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem && !misal) begin
                    stall   = 1'b1;
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (dbus.gnt) begin
                    cnt_d = '0;
                    if (dbus.rvalid) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall   = 1'b1;
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (dbus.rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated so the stall drops the instant reset asserts, not at the edge.
    assign stallreq_o = stall & rst_ni;

    always_comb begin
        dbus.req   = 1'b0;
        dbus.we    = 1'b0;
        dbus.addr  = '0;
        dbus.wdata = '0;
        dbus.be    = '0;
        if (state_q == ADDR) begin
            dbus.req   = 1'b1;
            dbus.we    = we_q;
            dbus.addr  = {addr_q[31:2], 2'b00};
            dbus.wdata = data_q;
            dbus.be    = 4'b1111;
            case (op_q)
                SB: begin
                    dbus.wdata = {4{data_q[7:0]}};
                    dbus.be    = 4'b0001 << addr_q[1:0];
                end
                SH: begin
                    dbus.wdata = {2{data_q[15:0]}};
                    dbus.be    = 4'b0011 << {addr_q[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_q[1:0])
            2'd0:    b = dbus.rdata[7:0];
            2'd1:    b = dbus.rdata[15:8];
            2'd2:    b = dbus.rdata[23:16];
            default: b = dbus.rdata[31:24];
        endcase
        h = addr_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
        case (op_q)
            LB:      ld_data = {{24{b[7]}}, b};
            LBU:     ld_data = {24'd0, b};
            LH:      ld_data = {{16{h[15]}}, h};
            LHU:     ld_data = {16'd0, h};
            default: ld_data = dbus.rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MEM_NOP;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            mwaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                op_q     <= mem_op_i;
                addr_q   <= mem_addr_i;
                data_q   <= mem_data_i;
                we_q     <= mem_we_i;
                mwaddr_q <= reg_waddr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (state_q == IDLE) begin
                reg_waddr_q <= reg_waddr_i;
                reg_wdata_q <= reg_wdata_i;
                reg_we_q    <= is_mem ? 1'b0 : reg_we_i;
                misalign_q  <= is_mem & misal;
            end else if (done) begin
                reg_waddr_q <= mwaddr_q;
                reg_we_q    <= ~we_q;
                if (!we_q) reg_wdata_q <= ld_data;
            end else if (tmo) begin
                reg_we_q  <= 1'b0;
                bus_err_q <= 1'b1;
            end
        end
    end

    assign reg_waddr_o = reg_waddr_q;
    assign reg_we_o    = reg_we_q;
    assign reg_wdata_o = reg_wdata_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table through a scoreboard queue,
// plus hand-written reset and pulse-width sequences.
module tb_mem_access;
    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2;
    localparam logic [3:0] LW = 4'd3, LBU = 4'd4, LHU = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;
    localparam int NEV = 255;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mwe;
        logic [4:0]  waddr;
        logic        rwe;
        logic [31:0] rwd;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic [3:0]  xbe;
        logic [31:0] xbwd;
        logic        xwe;
        logic [31:0] xwd;
        logic        xmis;
        logic        xerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mem_op = NOP;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        stall, mis, err;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt[18];
    vec_t exp_q[$];

    mem_access_if dbus ();

    mem_access dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_op_i    (mem_op),
        .mem_addr_i  (mem_addr),
        .mem_data_i  (mem_data),
        .mem_we_i    (mem_we),
        .reg_waddr_i (waddr_i),
        .reg_we_i    (we_i),
        .reg_wdata_i (wdata_i),
        .dbus        (dbus.master),
        .reg_waddr_o (waddr_o),
        .reg_we_o    (we_o),
        .reg_wdata_o (wdata_o),
        .stallreq_o  (stall),
        .misalign_o  (mis),
        .bus_err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int k, reqc, xk, xreq;
        bit fin, bus_op;
        vec_t e;
        string t;
        t = $sformatf("v%0d", idx);
        bus_op = !v.xmis && (v.op != NOP);
        if (!bus_op) begin
            xk = 0; xreq = 0;
        end else if (v.gd == NEV) begin
            xk = 16; xreq = 16;
        end else if (v.rd == NEV) begin
            xk = 1 + v.gd + 16; xreq = v.gd + 1;
        end else begin
            xk = 1 + v.gd + v.rd; xreq = v.gd + 1;
        end
        exp_q.push_back(v);
        mem_op = v.op; mem_addr = v.addr; mem_data = v.data;
        mem_we = v.mwe; waddr_i = v.waddr; we_i = v.rwe;
        wdata_i = v.rwd; dbus.rdata = v.rdata;
        k = 0; reqc = 0; fin = 0;
        while (!fin && k < 40) begin
            dbus.gnt = (k == 1 + v.gd);
            dbus.rvalid = (v.rd != NEV) && (k == 1 + v.gd + v.rd);
            #1;
            if (dbus.req) begin
                if (reqc == 0) begin
                    chk({t, "_be"}, {28'd0, dbus.be}, {28'd0, v.xbe});
                    chk({t, "_bwe"}, {31'd0, dbus.we}, {31'd0, v.mwe});
                    chk({t, "_badr"}, dbus.addr, {v.addr[31:2], 2'b00});
                    if (v.mwe) chk({t, "_bwd"}, dbus.wdata, v.xbwd);
                end
                reqc++;
            end
            if (!stall) fin = 1;
            @(negedge clk);
            dbus.gnt = 1'b0; dbus.rvalid = 1'b0;
            if (!fin) k++;
        end
        n_vec++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s_hang: stall never released", t);
        end
        e = exp_q.pop_front();
        chk({t, "_stallk"}, k, xk);
        chk({t, "_reqc"}, reqc, xreq);
        chk({t, "_mis"}, {31'd0, mis}, {31'd0, e.xmis});
        chk({t, "_err"}, {31'd0, err}, {31'd0, e.xerr});
        chk({t, "_we"}, {31'd0, we_o}, {31'd0, e.xwe});
        if (e.xwe) begin
            chk({t, "_wd"}, wdata_o, e.xwd);
            chk({t, "_wa"}, {27'd0, waddr_o}, {27'd0, e.waddr});
        end
        mem_op = NOP; we_i = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk({t, "_pulse"}, {30'd0, mis, err}, 32'd0);
    endtask

    initial begin
        vt[0]  = '{NOP, 32'h0, 32'h0, 0, 5, 1, 32'h1234, 0, 0, 32'h0,
                   4'h0, 32'h0, 1, 32'h1234, 0, 0};
        vt[1]  = '{SW, 32'h100, 32'hDEADBEEF, 1, 1, 0, 32'h0, 2, 1, 32'h0,
                   4'hF, 32'hDEADBEEF, 0, 32'h0, 0, 0};
        vt[2]  = '{LB, 32'h103, 32'h0, 0, 7, 1, 32'h0, 0, 1, 32'h80FF0000,
                   4'hF, 32'h0, 1, 32'hFFFFFF80, 0, 0};
        vt[3]  = '{LBU, 32'h103, 32'h0, 0, 8, 1, 32'h0, 1, 0, 32'h80FF0000,
                   4'hF, 32'h0, 1, 32'h00000080, 0, 0};
        vt[4]  = '{LHU, 32'h102, 32'h0, 0, 9, 1, 32'h0, 0, 0, 32'h80011234,
                   4'hF, 32'h0, 1, 32'h00008001, 0, 0};
        vt[5]  = '{LH, 32'h102, 32'h0, 0, 10, 1, 32'h0, 0, 2, 32'h80011234,
                   4'hF, 32'h0, 1, 32'hFFFF8001, 0, 0};
        vt[6]  = '{SB, 32'h101, 32'hAB, 1, 11, 0, 32'h0, 1, 1, 32'h0,
                   4'b0010, 32'hABABABAB, 0, 32'h0, 0, 0};
        vt[7]  = '{SH, 32'h102, 32'h5678, 1, 2, 0, 32'h0, 0, 0, 32'h0,
                   4'b1100, 32'h56785678, 0, 32'h0, 0, 0};
        vt[8]  = '{LW, 32'h102, 32'h0, 0, 3, 1, 32'h0, 0, 0, 32'h0,
                   4'h0, 32'h0, 0, 32'h0, 1, 0};
        vt[9]  = '{LH, 32'h101, 32'h0, 0, 4, 1, 32'h0, 0, 0, 32'h0,
                   4'h0, 32'h0, 0, 32'h0, 1, 0};
        vt[10] = '{LW, 32'h104, 32'h0, 0, 12, 1, 32'h0, 3, 0, 32'hCAFEF00D,
                   4'hF, 32'h0, 1, 32'hCAFEF00D, 0, 0};
        vt[11] = '{LW, 32'h200, 32'h0, 0, 6, 1, 32'h0, NEV, NEV, 32'h0,
                   4'hF, 32'h0, 0, 32'h0, 0, 1};
        vt[12] = '{LH, 32'h100, 32'h0, 0, 13, 1, 32'h0, 0, 1, 32'h12348001,
                   4'hF, 32'h0, 1, 32'hFFFF8001, 0, 0};
        vt[13] = '{LB, 32'h100, 32'h0, 0, 14, 1, 32'h0, 1, 1, 32'h0000007F,
                   4'hF, 32'h0, 1, 32'h0000007F, 0, 0};
        vt[14] = '{NOP, 32'h0, 32'h0, 0, 15, 0, 32'hABCD, 0, 0, 32'h0,
                   4'h0, 32'h0, 0, 32'h0, 0, 0};
        vt[15] = '{SW, 32'h204, 32'h11223344, 1, 16, 0, 32'h0, 0, NEV, 32'h0,
                   4'hF, 32'h11223344, 0, 32'h0, 0, 1};
        vt[16] = '{SW, 32'h101, 32'h55, 1, 17, 0, 32'h0, 0, 0, 32'h0,
                   4'h0, 32'h0, 0, 32'h0, 1, 0};
        vt[17] = '{SH, 32'h100, 32'hFFFF1234, 1, 18, 0, 32'h0, 0, 1, 32'h0,
                   4'b0011, 32'h12341234, 0, 32'h0, 0, 0};

        dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = '0;
        mem_op = LW; mem_addr = 32'h0; we_i = 1'b1;
        wdata_i = 32'h77; waddr_i = 5'd9;
        #3;
        chk("rst_req", {31'd0, dbus.req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb", {waddr_o, we_o, wdata_o[25:0]}, 32'd0);
        chk("rst_pulse", {30'd0, mis, err}, 32'd0);
        mem_op = NOP; we_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) run(i, vt[i]);

        mem_op = LW; mem_addr = 32'h300; mem_we = 1'b0;
        waddr_i = 5'd20; we_i = 1'b1;
        #1;
        chk("rs_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        dbus.gnt = 1'b1;
        #1;
        chk("rs_addr_req", {31'd0, dbus.req}, 32'd1);
        @(negedge clk);
        dbus.gnt = 1'b0;
        #1;
        chk("rs_resp_stall", {31'd0, stall}, 32'd1);
        chk("rs_resp_req", {31'd0, dbus.req}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_async_req", {31'd0, dbus.req}, 32'd0);
        chk("rs_async_stall", {31'd0, stall}, 32'd0);
        chk("rs_async_we", {31'd0, we_o}, 32'd0);
        mem_op = NOP; we_i = 1'b1; wdata_i = 32'h55; waddr_i = 5'd3;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_after_we", {31'd0, we_o}, 32'd1);
        chk("rs_after_wd", wdata_o, 32'h55);
        chk("rs_after_req", {30'd0, dbus.req, stall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
